// File: rtl/instruction_prefetch.sv
// Sequential instruction prefetcher between a CPU fetch port (Avalon-MM read
// agent) and instruction memory (pipelined Avalon-MM read host).
// Streams words ahead of the CPU into a small tagged FIFO; a non-sequential
// fetch flushes the FIFO and drops responses still in flight.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_address/cpu_read          CPU fetch request (word aligned)
//   cpu_waitrequest               request not accepted this cycle (combinational)
//   cpu_readdata/cpu_readdatavalid  returned word, 1 cycle after acceptance
//   mem_address/mem_read          memory read request (registered)
//   mem_waitrequest               memory stall
//   mem_readdata/mem_readdatavalid  in-order memory responses
module instruction_prefetch #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MAX_PENDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    output logic        cpu_waitrequest,
    output logic [31:0] cpu_readdata,
    output logic        cpu_readdatavalid,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_n;
    logic [31:0]     fetch_addr_q, fetch_addr_n;
    logic [31:0]     exp_tag_q, exp_tag_n;
    logic [CW-1:0]   count_q, count_n;
    logic [CW-1:0]   pending_q, pending_n;
    logic [CW-1:0]   discard_q, discard_n;
    logic            stale_q, stale_n;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_n;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_n;
    logic            mem_read_n;
    logic [31:0]     mem_address_n;
    logic            rvalid_n;
    logic [31:0]     rdata_n;

    logic [31:0]     tag_mem  [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic [31:0]     addr_al;
    logic            fifo_empty, hit, accept, resp, drop, push, redirect;
    logic [CW:0]     occ_n;

    // Byte offset of the fetch address is don't-care.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^cpu_address[1:0];

    assign addr_al = {cpu_address[31:2], 2'b00};

    // Request decode, FIFO bookkeeping and next memory request.
    always_comb begin
        fifo_empty    = (count_q == '0);
        hit           = cpu_read && !fifo_empty && (tag_mem[rd_ptr_q] == addr_al);
        accept        = mem_read && !mem_waitrequest;
        resp          = mem_readdatavalid && (pending_q != '0);
        drop          = resp && (discard_q != '0);
        redirect      = cpu_read && !hit &&
                        ((state_q == IDLE) || !fifo_empty || (exp_tag_q != addr_al));
        push          = resp && !drop && !redirect;

        cpu_waitrequest = cpu_read && !hit;

        state_n       = state_q;
        fetch_addr_n  = fetch_addr_q;
        exp_tag_n     = exp_tag_q;
        count_n       = count_q;
        discard_n     = discard_q;
        stale_n       = stale_q;
        wr_ptr_n      = wr_ptr_q;
        rd_ptr_n      = rd_ptr_q;
        rvalid_n      = hit;
        rdata_n       = hit ? data_mem[rd_ptr_q] : cpu_readdata;

        pending_n     = pending_q + CW'(accept) - CW'(resp);

        if (redirect) begin
            // Everything still in flight after this edge belongs to the old stream;
            // a request held by waitrequest is added to discard once accepted.
            state_n      = STREAM;
            fetch_addr_n = addr_al;
            exp_tag_n    = addr_al;
            count_n      = '0;
            rd_ptr_n     = wr_ptr_q;
            discard_n    = pending_n;
            stale_n      = mem_read && !accept;
        end else begin
            discard_n = discard_q - CW'(drop) + CW'(stale_q && accept);
            stale_n   = stale_q && !accept;
            if (accept && !stale_q)
                fetch_addr_n = fetch_addr_q + 32'd4;
            if (push) begin
                exp_tag_n = exp_tag_q + 32'd4;
                wr_ptr_n  = wr_ptr_q + AW'(1);
            end
            if (hit)
                rd_ptr_n = rd_ptr_q + AW'(1);
            count_n = count_q + CW'(push) - CW'(hit);
        end

        occ_n = {1'b0, count_n} + {1'b0, pending_n};

        // A stalled request must stay stable until memory takes it.
        if (mem_read && mem_waitrequest) begin
            mem_read_n    = 1'b1;
            mem_address_n = mem_address;
        end else begin
            mem_read_n    = (state_n == STREAM) && (occ_n < (CW+1)'(DEPTH)) &&
                            (pending_n < CW'(MAX_PENDING));
            mem_address_n = fetch_addr_n;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            fetch_addr_q      <= '0;
            exp_tag_q         <= '0;
            count_q           <= '0;
            pending_q         <= '0;
            discard_q         <= '0;
            stale_q           <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            mem_read          <= 1'b0;
            mem_address       <= '0;
            cpu_readdatavalid <= 1'b0;
            cpu_readdata      <= '0;
        end else begin
            state_q           <= state_n;
            fetch_addr_q      <= fetch_addr_n;
            exp_tag_q         <= exp_tag_n;
            count_q           <= count_n;
            pending_q         <= pending_n;
            discard_q         <= discard_n;
            stale_q           <= stale_n;
            wr_ptr_q          <= wr_ptr_n;
            rd_ptr_q          <= rd_ptr_n;
            mem_read          <= mem_read_n;
            mem_address       <= mem_address_n;
            cpu_readdatavalid <= rvalid_n;
            cpu_readdata      <= rdata_n;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q]  <= exp_tag_q;
            data_mem[wr_ptr_q] <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
module tb_instruction_prefetch;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned MAX_PENDING = 2;
    localparam int          BUDGET      = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;

    instruction_prefetch #(.DEPTH(DEPTH), .MAX_PENDING(MAX_PENDING)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory image: every word's content is a fixed function of its address.
    function automatic logic [31:0] memdata(input logic [31:0] a);
        return ({a[15:0], a[31:16]} ^ 32'hDEAD_BEEF) + a;
    endfunction

    // Pipelined memory model with programmable latency and stall rate.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    logic [31:0] mem_log[$];
    int          cyc = 0;
    int          mem_lat = 1;
    int          wr_pct = 0;
    bit          wr_force = 1'b0;
    int          out_cnt = 0, max_out = 0, stab_viol = 0, n_valid = 0, n_acc = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst) begin
            mq.delete();
            mem_readdatavalid = 1'b0;
            mem_readdata      = '0;
            mem_waitrequest   = 1'b0;
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = memdata(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                mem_readdatavalid = 1'b0;
                mem_readdata      = '0;
            end
            mem_waitrequest = wr_force || (32'($urandom_range(99)) < 32'(wr_pct));
        end
    end

    // Observation of both ports between clock edges.
    always @(negedge clk) begin
        mreq_t r;
        int    cur;
        if (!rst) begin
            out_cnt   = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!mem_read || mem_address !== prev_addr))
                stab_viol = stab_viol + 1;
            if (mem_read && !mem_waitrequest) begin
                r.addr = mem_address;
                r.due  = cyc + mem_lat;
                mq.push_back(r);
                mem_log.push_back(mem_address);
            end
            cur = out_cnt + ((mem_read && !mem_waitrequest) ? 1 : 0) - (mem_readdatavalid ? 1 : 0);
            if (cur > max_out) max_out = cur;
            out_cnt   = cur;
            prev_hold = mem_read && mem_waitrequest;
            prev_addr = mem_address;
            if (cpu_readdatavalid) n_valid = n_valid + 1;
            if (cpu_read && !cpu_waitrequest) n_acc = n_acc + 1;
        end
    end

    // CPU fetch stimulus: returns wait cycles and the word seen one cycle after acceptance.
    task automatic cpu_fetch(input logic [31:0] a, output int waits,
                             output logic vld, output logic [31:0] dat);
        @(posedge clk); #1;
        cpu_read    = 1'b1;
        cpu_address = a;
        waits       = 0;
        forever begin
            @(negedge clk);
            if (!cpu_waitrequest) break;
            waits = waits + 1;
            if (waits >= BUDGET) break;
        end
        if (waits >= BUDGET) begin
            @(posedge clk); #1;
            cpu_read = 1'b0;
            vld = 1'b0;
            dat = '0;
            return;
        end
        @(posedge clk); #1;
        cpu_read = 1'b0;
        @(negedge clk);
        vld = cpu_readdatavalid;
        dat = cpu_readdata;
    endtask

    function automatic int find_from(input logic [31:0] a, input int from);
        for (int i = from; i < mem_log.size(); i++)
            if (mem_log[i] == a) return i;
        return -1;
    endfunction

    task automatic test_reset();
        int base;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address got %h exp 0", mem_address); end
        checks++; if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", cpu_readdatavalid); end
        checks++; if (cpu_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", cpu_readdata); end
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b exp 0", cpu_waitrequest); end
        @(posedge clk); #1;
        rst  = 1'b1;
        base = mem_log.size();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL idle_no_prefetch got %b exp 0", mem_read); end
        checks++; if (mem_log.size() != base) begin errors++; $display("FAIL idle_no_reads got %0d exp %0d", mem_log.size(), base); end
    endtask

    task automatic test_first_fetch();
        int waits, base;
        logic vld;
        logic [31:0] dat, a;
        mem_lat = 1; wr_pct = 0;
        base = mem_log.size();
        cpu_fetch(32'h0, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h0)) begin errors++; $display("FAIL first_data got %b/%h exp 1/%h", vld, dat, memdata(32'h0)); end
        checks++; if (waits > mem_lat + 3) begin errors++; $display("FAIL first_latency got %0d exp <=%0d", waits, mem_lat + 3); end
        for (int i = 1; i < 4; i++) begin
            a = 32'(i * 4);
            cpu_fetch(a, waits, vld, dat);
            checks++; if (waits != 0 || !vld || dat !== memdata(a)) begin
                errors++; $display("FAIL seq_hit_%0h got w%0d %b/%h exp w0 1/%h", a, waits, vld, dat, memdata(a));
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= mem_log.size() || mem_log[base + i] !== 32'(i * 4)) begin
                errors++; $display("FAIL mem_addr_seq_%0d got %h exp %h", i,
                                   (base + i < mem_log.size()) ? mem_log[base + i] : 32'hx, 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall_fill();
        int waits, base, idx;
        logic vld;
        logic [31:0] dat, a;
        base = mem_log.size();
        cpu_fetch(32'h40, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h40)) begin errors++; $display("FAIL stall_first got %b/%h exp 1/%h", vld, dat, memdata(32'h40)); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL full_mem_read got %b exp 0", mem_read); end
        idx = find_from(32'h40, base);
        checks++; if (idx < 0 || mem_log.size() - idx != DEPTH + 1 || mem_log[mem_log.size() - 1] !== 32'h50) begin
            errors++; $display("FAIL full_buffered got %0d reads exp %0d ending 00000050", (idx < 0) ? -1 : mem_log.size() - idx, DEPTH + 1);
        end
        for (int i = 1; i <= 4; i++) begin
            a = 32'h40 + 32'(i * 4);
            cpu_fetch(a, waits, vld, dat);
            checks++; if (waits != 0 || !vld || dat !== memdata(a)) begin
                errors++; $display("FAIL full_hit_%0h got w%0d %b/%h exp w0 1/%h", a, waits, vld, dat, memdata(a));
            end
        end
    endtask

    task automatic test_redirect();
        int waits, base, idx;
        logic vld;
        logic [31:0] dat;
        mem_lat = 3; wr_pct = 0;
        cpu_fetch(32'h100, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h100)) begin errors++; $display("FAIL stream_100 got %b/%h exp 1/%h", vld, dat, memdata(32'h100)); end
        cpu_fetch(32'h104, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h104)) begin errors++; $display("FAIL stream_104 got %b/%h exp 1/%h", vld, dat, memdata(32'h104)); end
        base = mem_log.size();
        cpu_fetch(32'h200, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h200)) begin errors++; $display("FAIL redirect_data got %b/%h exp 1/%h", vld, dat, memdata(32'h200)); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        idx = find_from(32'h200, base);
        checks++; if (idx < 0 || idx + 1 >= mem_log.size() || mem_log[idx + 1] !== 32'h204) begin
            errors++; $display("FAIL redirect_next_addr got %h exp 00000204",
                               (idx >= 0 && idx + 1 < mem_log.size()) ? mem_log[idx + 1] : 32'hx);
        end
        checks++; if (n_valid != n_acc) begin errors++; $display("FAIL redirect_valid_count got %0d exp %0d", n_valid, n_acc); end
    endtask

    task automatic test_waitreq_redirect();
        int waits, base;
        logic vld;
        logic [31:0] dat, held;
        mem_lat = 2; wr_pct = 0;
        cpu_fetch(32'h300, waits, vld, dat);
        cpu_fetch(32'h304, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h304)) begin errors++; $display("FAIL wr_stream got %b/%h exp 1/%h", vld, dat, memdata(32'h304)); end
        wr_force = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL wr_held_read got %b exp 1", mem_read); end
        held = mem_address;
        base = mem_log.size();
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_address = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_read !== 1'b1 || mem_address !== held) begin
                errors++; $display("FAIL wr_stable_%0d got %b/%h exp 1/%h", i, mem_read, mem_address, held);
            end
        end
        wr_force = 1'b0;
        waits = 0;
        while (cpu_waitrequest && waits < BUDGET) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk); #1;
        cpu_read = 1'b0;
        @(negedge clk);
        checks++; if (!cpu_readdatavalid || cpu_readdata !== memdata(32'h500)) begin
            errors++; $display("FAIL wr_redirect_data got %b/%h exp 1/%h", cpu_readdatavalid, cpu_readdata, memdata(32'h500));
        end
        checks++; if (mem_log.size() < base + 2 || mem_log[base] !== held || mem_log[base + 1] !== 32'h500) begin
            errors++; $display("FAIL wr_issue_order got %h,%h exp %h,00000500",
                               (mem_log.size() > base) ? mem_log[base] : 32'hx,
                               (mem_log.size() > base + 1) ? mem_log[base + 1] : 32'hx, held);
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL wr_stability got %0d exp 0", stab_viol); end
    endtask

    task automatic test_wrap();
        int waits, base, idx;
        logic vld;
        logic [31:0] dat;
        mem_lat = 1; wr_pct = 0;
        base = mem_log.size();
        cpu_fetch(32'hFFFF_FFF8, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'hFFFF_FFF8)) begin errors++; $display("FAIL wrap_first got %b/%h exp 1/%h", vld, dat, memdata(32'hFFFF_FFF8)); end
        repeat (6) @(posedge clk);
        cpu_fetch(32'hFFFF_FFFC, waits, vld, dat);
        checks++; if (waits != 0 || !vld || dat !== memdata(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_fffc got w%0d %b/%h exp w0 1/%h", waits, vld, dat, memdata(32'hFFFF_FFFC)); end
        cpu_fetch(32'h0, waits, vld, dat);
        checks++; if (waits != 0 || !vld || dat !== memdata(32'h0)) begin errors++; $display("FAIL wrap_zero got w%0d %b/%h exp w0 1/%h", waits, vld, dat, memdata(32'h0)); end
        idx = find_from(32'hFFFF_FFF8, base);
        checks++; if (idx < 0 || idx + 2 >= mem_log.size() || mem_log[idx + 1] !== 32'hFFFF_FFFC || mem_log[idx + 2] !== 32'h0) begin
            errors++; $display("FAIL wrap_addr_seq got %0d exp FFFFFFF8,FFFFFFFC,00000000", idx);
        end
    endtask

    task automatic test_random();
        int waits, bad, acc0, val0;
        logic vld;
        logic [31:0] dat, a;
        bad = 0;
        a = 32'h1000;
        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) begin
                mem_lat = 1 + $urandom_range(3);
                wr_pct  = $urandom_range(40);
            end
            if ($urandom_range(99) < 25) begin
                a = {$urandom_range(1) ? 16'hFFFF : 16'h0000, 8'h0, 6'($urandom_range(63)), 2'b00};
            end else begin
                a = a + 32'd4;
            end
            cpu_fetch(a, waits, vld, dat);
            checks++;
            if (!vld || dat !== memdata(a)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_fetch_%0d addr %h got %b/%h exp 1/%h", n, a, vld, dat, memdata(a));
            end
            repeat ($urandom_range(3)) @(posedge clk);
        end
        wr_pct = 0;
        acc0 = n_acc; val0 = n_valid;
        repeat (2) @(negedge clk);
        checks++; if (val0 != acc0) begin errors++; $display("FAIL rand_valid_count got %0d exp %0d", val0, acc0); end
        checks++; if (max_out > MAX_PENDING) begin errors++; $display("FAIL rand_max_pending got %0d exp <=%0d", max_out, MAX_PENDING); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stability got %0d exp 0", stab_viol); end
    endtask

    task automatic test_reset_mid();
        int waits, base;
        logic vld;
        logic [31:0] dat;
        mem_lat = 1; wr_pct = 0;
        cpu_fetch(32'h800, waits, vld, dat);
        repeat (8) @(posedge clk);
        cpu_fetch(32'h804, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h804)) begin errors++; $display("FAIL pre_reset_hit got %b/%h exp 1/%h", vld, dat, memdata(32'h804)); end
        #1 rst = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_address !== 32'h0) begin errors++; $display("FAIL async_mem got %b/%h exp 0/0", mem_read, mem_address); end
        checks++; if (cpu_readdatavalid !== 1'b0 || cpu_readdata !== 32'h0) begin errors++; $display("FAIL async_cpu got %b/%h exp 0/0", cpu_readdatavalid, cpu_readdata); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        base = mem_log.size();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || mem_log.size() != base) begin errors++; $display("FAIL post_reset_idle got %b/%0d exp 0/%0d", mem_read, mem_log.size(), base); end
        cpu_fetch(32'h900, waits, vld, dat);
        checks++; if (!vld || dat !== memdata(32'h900)) begin errors++; $display("FAIL post_reset_fetch got %b/%h exp 1/%h", vld, dat, memdata(32'h900)); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_fill();
        test_redirect();
        test_waitreq_redirect();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
